tug_of_war_field: RTL and testbench
===================================

Name: tug_of_war_field

Overview:
- Parametrised tug-of-war playfield: one module replaces the per-light center/edge cells with a single position register driving a one-hot row of NUM_LIGHTS lights.
- Two players press L/R keys. Each press moves the lit position one step toward the presser.
- Pushing off the presser's edge wins the round, increments that player's score, and restarts play from center after a hold interval.
- Sits between key synchronisers and the LED/HEX display drivers. Adds press edge detection, scoring, round restart and match-over, none of which the single-light cells had.

Parameters:
- NUM_LIGHTS, 9, number of lights; odd, >= 3. Center index C = (NUM_LIGHTS-1)/2.
- SCORE_W, 3, width of each score counter.
- MAX_SCORE, 7, score that ends the match; 1 <= MAX_SCORE <= 2^SCORE_W - 1.
- HOLD_CYCLES, 4, cycles spent in RESULT before the next round starts; >= 1.

Ports:
- Clock, input, 1, system clock; all state updates on posedge.
- Reset, input, 1, synchronous, active-high.
- L, input, 1, left key level, already synchronised to Clock.
- R, input, 1, right key level, already synchronised to Clock.
- lights, output, NUM_LIGHTS, one-hot position; bit NUM_LIGHTS-1 is leftmost, bit 0 rightmost.
- left_score, output, SCORE_W, left player's round wins.
- right_score, output, SCORE_W, right player's round wins.
- winner, output, 2, last round winner: 2'b10 left, 2'b01 right, 2'b00 none.
- round_over, output, 1, high while in RESULT or MATCH_OVER.

Behaviour:
- Clock/reset: single clock "Clock"; reset "Reset" is synchronous, active-high.
- Edge detect:
  - L_prev/R_prev register L/R every cycle, including during Reset, so a key held through reset does not count as a press.
  - lp = L & ~L_prev; rp = R & ~R_prev.
  - Effective move: mvL = lp & ~rp; mvR = rp & ~lp. lp & rp together is no move.
- Reset values: pos = C; lights = one-hot bit C; scores 0; winner 2'b00; round_over 0; state PLAY; hold counter 0.
- States:
  - PLAY:
    - mvL with pos < NUM_LIGHTS-1: pos+1.
    - mvR with pos > 0: pos-1.
    - mvL with pos == NUM_LIGHTS-1: left wins, go to RESULT.
    - mvR with pos == 0: right wins, go to RESULT.
    - Otherwise hold.
    - Latency: a press edge sampled at posedge k updates lights after posedge k (one cycle, no extra pipelining).
  - RESULT entry, same edge:
    - Winner's score += 1, saturating at MAX_SCORE.
    - winner set.
    - lights = all zeros.
    - Hold counter cleared.
  - RESULT:
    - Counter increments each cycle; all key presses ignored (edge registers still track).
    - After HOLD_CYCLES cycles in RESULT: if either score == MAX_SCORE go to MATCH_OVER, else go to PLAY with pos = C.
    - winner keeps its value into the next PLAY.
  - MATCH_OVER:
    - lights = all ones.
    - Scores and winner frozen; presses ignored.
    - Left only by Reset.
- Outputs: lights decoded combinationally from state and pos; only PLAY shows one-hot.
- Reset mid-round or in any state returns everything to reset values on the next posedge. Reset takes priority over all moves.
- Key held high: counts as one press only.
- Alternating L/R on consecutive cycles: each cycle is a separate edge and moves once.

Test Plan:
All scenarios use NUM_LIGHTS=5, MAX_SCORE=2, HOLD_CYCLES=4.
1. Reset -> lights=00100, scores 0/0, winner=00, round_over=0. Hold L high through Reset release -> no movement.
2. Three separate L pulses (1 cycle high, 1 low) -> lights 01000, then 10000, then RESULT: lights=00000, left_score=1, winner=10, round_over=1. After 4 cycles -> lights=00100, round_over=0.
3. L and R rise on the same cycle -> lights unchanged. L held high for 10 cycles -> exactly one step left.
4. L pulses during RESULT -> ignored: left_score unchanged and restart at center on schedule.
5. Left wins two rounds -> left_score=2. After hold -> MATCH_OVER: lights=11111, round_over=1, presses ignored. Reset -> full reset values.
6. Assert Reset at pos=10000 mid-round -> next cycle lights=00100, scores unchanged from reset values (0/0).

Source files
------------

// File: rtl/tug_of_war_field.sv
// Tug-of-war playfield: one position register drives a one-hot row of lights,
// with press edge detection, per-player scoring, timed round restart and match-over.
module tug_of_war_field #(
    parameter int unsigned NUM_LIGHTS  = 9,
    parameter int unsigned SCORE_W     = 3,
    parameter int unsigned MAX_SCORE   = 7,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  L,
    input  logic                  R,
    output logic [NUM_LIGHTS-1:0] lights,
    output logic [SCORE_W-1:0]    left_score,
    output logic [SCORE_W-1:0]    right_score,
    output logic [1:0]            winner,
    output logic                  round_over
);

    localparam int unsigned PosW  = $clog2(NUM_LIGHTS);
    localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [PosW-1:0]    Center   = PosW'((NUM_LIGHTS - 1) / 2);
    localparam logic [PosW-1:0]    LeftEdge = PosW'(NUM_LIGHTS - 1);
    localparam logic [HoldW-1:0]   HoldLast = HoldW'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] ScoreMax = SCORE_W'(MAX_SCORE);

    typedef enum logic [1:0] {
        StPlay,
        StResult,
        StMatchOver
    } state_e;

    state_e             state_q, state_d;
    logic [PosW-1:0]    pos_q, pos_d;
    logic [HoldW-1:0]   hold_q, hold_d;
    logic [SCORE_W-1:0] left_q, left_d;
    logic [SCORE_W-1:0] right_q, right_d;
    logic [1:0]         winner_q, winner_d;
    logic               l_prev_q, r_prev_q;

    logic lp, rp, mv_l, mv_r;

    // Edge registers run through reset so a key held across reset is not a press.
    always_ff @(posedge Clock) begin
        l_prev_q <= L;
        r_prev_q <= R;
    end

    assign lp   = L & ~l_prev_q;
    assign rp   = R & ~r_prev_q;
    assign mv_l = lp & ~rp;
    assign mv_r = rp & ~lp;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= StPlay;
            pos_q    <= Center;
            hold_q   <= '0;
            left_q   <= '0;
            right_q  <= '0;
            winner_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            hold_q   <= hold_d;
            left_q   <= left_d;
            right_q  <= right_d;
            winner_q <= winner_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        hold_d   = hold_q;
        left_d   = left_q;
        right_d  = right_q;
        winner_d = winner_q;

        unique case (state_q)
            StPlay: begin
                if (mv_l) begin
                    if (pos_q == LeftEdge) begin
                        state_d  = StResult;
                        winner_d = 2'b10;
                        hold_d   = '0;
                        if (left_q != ScoreMax) begin
                            left_d = left_q + SCORE_W'(1);
                        end
                    end else begin
                        pos_d = pos_q + PosW'(1);
                    end
                end else if (mv_r) begin
                    if (pos_q == '0) begin
                        state_d  = StResult;
                        winner_d = 2'b01;
                        hold_d   = '0;
                        if (right_q != ScoreMax) begin
                            right_d = right_q + SCORE_W'(1);
                        end
                    end else begin
                        pos_d = pos_q - PosW'(1);
                    end
                end
            end

            StResult: begin
                // Exit on the HOLD_CYCLES-th edge spent in this state.
                if (hold_q == HoldLast) begin
                    if ((left_q == ScoreMax) || (right_q == ScoreMax)) begin
                        state_d = StMatchOver;
                    end else begin
                        state_d = StPlay;
                        pos_d   = Center;
                    end
                end else begin
                    hold_d = hold_q + HoldW'(1);
                end
            end

            StMatchOver: begin
                state_d = StMatchOver;
            end

            default: begin
                state_d = StPlay;
                pos_d   = Center;
            end
        endcase
    end

    always_comb begin
        lights = '0;
        unique case (state_q)
            StPlay:      lights = NUM_LIGHTS'(1) << pos_q;
            StResult:    lights = '0;
            StMatchOver: lights = '1;
            default:     lights = '0;
        endcase
    end

    assign left_score  = left_q;
    assign right_score = right_q;
    assign winner      = winner_q;
    assign round_over  = (state_q != StPlay);

endmodule

// File: tb/tb_tug_of_war_field.sv
// Randomised plus directed bench for tug_of_war_field; a game-rules model feeds an
// expectation queue that a free-running monitor drains one entry per clock.
module tb_tug_of_war_field;

    localparam int unsigned N    = 5;
    localparam int unsigned SW   = 3;
    localparam int unsigned MAXS = 2;
    localparam int unsigned HOLD = 4;
    localparam int unsigned CTR  = (N - 1) / 2;

    logic          clk;
    logic          rst;
    logic          key_l;
    logic          key_r;
    logic [N-1:0]  lights;
    logic [SW-1:0] left_score;
    logic [SW-1:0] right_score;
    logic [1:0]    winner;
    logic          round_over;

    tug_of_war_field #(
        .NUM_LIGHTS (N),
        .SCORE_W    (SW),
        .MAX_SCORE  (MAXS),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .Clock      (clk),
        .Reset      (rst),
        .L          (key_l),
        .R          (key_r),
        .lights     (lights),
        .left_score (left_score),
        .right_score(right_score),
        .winner     (winner),
        .round_over (round_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0]  lights;
        logic [SW-1:0] ls;
        logic [SW-1:0] rs;
        logic [1:0]    win;
        logic          ro;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Game model: mode 0 = playing, 1 = showing result, 2 = match finished.
    int m_mode, m_pos, m_ls, m_rs, m_win, m_left_to_wait;
    bit m_prev_l, m_prev_r;

    task automatic model_reset();
        m_mode = 0;
        m_pos  = CTR;
        m_ls   = 0;
        m_rs   = 0;
        m_win  = 0;
        m_left_to_wait = 0;
    endtask

    task automatic award(input bit left_won);
        if (left_won) begin
            m_ls  = (m_ls + 1 > MAXS) ? MAXS : m_ls + 1;
            m_win = 2;
        end else begin
            m_rs  = (m_rs + 1 > MAXS) ? MAXS : m_rs + 1;
            m_win = 1;
        end
        m_mode = 1;
        m_left_to_wait = HOLD;
    endtask

    task automatic model_step(input bit l, input bit r, input bit rs_in);
        bit press_l, press_r;
        press_l  = l && !m_prev_l;
        press_r  = r && !m_prev_r;
        m_prev_l = l;
        m_prev_r = r;
        if (rs_in) begin
            model_reset();
        end else if (m_mode == 0) begin
            if (press_l && !press_r) begin
                if (m_pos == N - 1) award(1'b1);
                else m_pos = m_pos + 1;
            end else if (press_r && !press_l) begin
                if (m_pos == 0) award(1'b0);
                else m_pos = m_pos - 1;
            end
        end else if (m_mode == 1) begin
            m_left_to_wait = m_left_to_wait - 1;
            if (m_left_to_wait == 0) begin
                if (m_ls == MAXS || m_rs == MAXS) begin
                    m_mode = 2;
                end else begin
                    m_mode = 0;
                    m_pos  = CTR;
                end
            end
        end
    endtask

    function automatic exp_t model_outputs();
        exp_t e;
        int   row;
        row = 0;
        if (m_mode == 0) row = 1 << m_pos;
        else if (m_mode == 2) row = (1 << N) - 1;
        e.lights = row[N-1:0];
        e.ls     = m_ls[SW-1:0];
        e.rs     = m_rs[SW-1:0];
        e.win    = m_win[1:0];
        e.ro     = (m_mode != 0);
        return e;
    endfunction

    // Inputs change on the falling edge; the expectation covers the next rising edge.
    task automatic step(input bit l, input bit r, input bit rs_in);
        @(negedge clk);
        key_l = l;
        key_r = r;
        rst   = rs_in;
        model_step(l, r, rs_in);
        q.push_back(model_outputs());
    endtask

    task automatic pulse_l();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("lights", int'(lights), int'(e.lights));
                check("left_score", int'(left_score), int'(e.ls));
                check("right_score", int'(right_score), int'(e.rs));
                check("winner", int'(winner), int'(e.win));
                check("round_over", int'(round_over), int'(e.ro));
            end
        end
    end

    initial begin : driver
        int waited;
        key_l = 1'b0;
        key_r = 1'b0;
        rst   = 1'b1;
        m_prev_l = 1'b0;
        m_prev_r = 1'b0;
        model_reset();

        // Reset values, and L held through reset release does not move.
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Three left pulses win a round, then restart at center after the hold.
        repeat (3) pulse_l();
        idle(6);

        // Simultaneous rise is no move; long hold is one step; alternate keys.
        step(1'b1, 1'b1, 1'b0);
        idle(1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
        idle(1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        idle(1);

        // Presses during the result hold are ignored.
        step(1'b0, 1'b0, 1'b1);
        repeat (3) pulse_l();
        repeat (2) pulse_l();
        idle(4);

        // Second win reaches the match limit; presses ignored until reset.
        repeat (3) pulse_l();
        idle(5);
        repeat (4) pulse_l();
        step(1'b0, 1'b1, 1'b0);
        idle(2);
        step(1'b0, 1'b0, 1'b1);
        idle(1);

        // Reset in the middle of a round at the left-most light.
        repeat (2) pulse_l();
        step(1'b0, 1'b0, 1'b1);
        idle(2);

        // Right side wins a round too.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        idle(5);

        // Random play with rare resets.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 40),
                 ($urandom_range(0, 999) < 3));
        end
        idle(2);

        waited = 0;
        while (q.size() != 0 && waited < 10) begin
            @(posedge clk);
            #2;
            waited++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
